// File: rtl/msu_sd_arbiter_if.sv
// Bus bundle for msu_sd_arbiter: audio/data requester handshakes plus the shared SD host port.
// The arbiter uses the slave modport; requesters and host together use master.
interface msu_sd_arbiter_if;
    logic        aud_rd;
    logic [20:0] aud_lba;
    logic        aud_urgent;
    logic        aud_ack;
    logic        aud_buff_wr;
    logic        aud_done;
    logic        dat_rd;
    logic [20:0] dat_lba;
    logic        dat_ack;
    logic        dat_buff_wr;
    logic        dat_done;
    logic [20:0] sd_lba;
    logic        sd_rd;
    logic        sd_ack;
    logic        sd_buff_wr;
    logic        owner;
    logic        busy;
    logic        short_err;
    logic        timeout_err;

    modport slave (
        input  aud_rd, aud_lba, aud_urgent, dat_rd, dat_lba, sd_ack, sd_buff_wr,
        output aud_ack, aud_buff_wr, aud_done, dat_ack, dat_buff_wr, dat_done,
               sd_lba, sd_rd, owner, busy, short_err, timeout_err
    );

    modport master (
        output aud_rd, aud_lba, aud_urgent, dat_rd, dat_lba, sd_ack, sd_buff_wr,
        input  aud_ack, aud_buff_wr, aud_done, dat_ack, dat_buff_wr, dat_done,
               sd_lba, sd_rd, owner, busy, short_err, timeout_err
    );
endinterface

// File: rtl/msu_sd_arbiter.sv
// Two-requester (audio/data) arbiter for a single SD sector-read host port.
// Define MSU_SD_ARB_TIMEOUT_EN to abort requests the host never acknowledges.
module msu_sd_arbiter #(
    parameter int SECTOR_WORDS   = 256,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    msu_sd_arbiter_if.slave       bus
);
    typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

    localparam logic [8:0] WORD_MAX  = 9'd256;
    localparam logic [8:0] WORD_GOAL = 9'(SECTOR_WORDS);

    if (SECTOR_WORDS < 1 || SECTOR_WORDS > 256 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("msu_sd_arbiter: parameter out of range");
    end

    state_t      state_reg;
    logic [20:0] sd_lba_reg;
    logic        sd_rd_reg;
    logic        owner_reg;
    logic        busy_reg;
    logic        last_grant_reg;
    logic        aud_ack_reg;
    logic        dat_ack_reg;
    logic        aud_done_reg;
    logic        dat_done_reg;
    logic        short_err_reg;
    logic [8:0]  word_count_reg;
    logic        grant_aud;
    logic        strobe;

`ifdef MSU_SD_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] timeout_cnt_reg;
    logic        timeout_err_reg;
    assign bus.timeout_err = timeout_err_reg;
`else
    assign bus.timeout_err = 1'b0;
`endif

    // last_grant_reg = 1 means data won last, so audio takes the next tie.
    always_comb begin
        grant_aud = 1'b0;
        if (bus.aud_rd && bus.aud_urgent)
            grant_aud = 1'b1;
        else if (bus.aud_rd && !bus.dat_rd)
            grant_aud = 1'b1;
        else if (bus.aud_rd && bus.dat_rd)
            grant_aud = last_grant_reg;
    end

    assign strobe = (state_reg == XFER) && bus.sd_ack && bus.sd_buff_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            sd_lba_reg     <= '0;
            sd_rd_reg      <= 1'b0;
            owner_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            last_grant_reg <= 1'b1;
            aud_ack_reg    <= 1'b0;
            dat_ack_reg    <= 1'b0;
            aud_done_reg   <= 1'b0;
            dat_done_reg   <= 1'b0;
            short_err_reg  <= 1'b0;
            word_count_reg <= '0;
`ifdef MSU_SD_ARB_TIMEOUT_EN
            timeout_cnt_reg <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            aud_ack_reg   <= 1'b0;
            dat_ack_reg   <= 1'b0;
            aud_done_reg  <= 1'b0;
            dat_done_reg  <= 1'b0;
            short_err_reg <= 1'b0;
`ifdef MSU_SD_ARB_TIMEOUT_EN
            timeout_err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (bus.aud_rd || bus.dat_rd) begin
                        sd_lba_reg     <= grant_aud ? bus.aud_lba : bus.dat_lba;
                        owner_reg      <= !grant_aud;
                        last_grant_reg <= !grant_aud;
                        word_count_reg <= '0;
                        sd_rd_reg      <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= REQ;
`ifdef MSU_SD_ARB_TIMEOUT_EN
                        timeout_cnt_reg <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus.sd_ack) begin
                        sd_rd_reg   <= 1'b0;
                        aud_ack_reg <= !owner_reg;
                        dat_ack_reg <= owner_reg;
                        state_reg   <= XFER;
                    end
`ifdef MSU_SD_ARB_TIMEOUT_EN
                    else if (timeout_cnt_reg == TIMEOUT_LAST) begin
                        sd_rd_reg       <= 1'b0;
                        busy_reg        <= 1'b0;
                        timeout_err_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 16'd1;
                    end
`endif
                end
                XFER: begin
                    // Host dropping ack ends the sector; the count is final here.
                    if (!bus.sd_ack) begin
                        aud_done_reg  <= !owner_reg;
                        dat_done_reg  <= owner_reg;
                        short_err_reg <= (word_count_reg != WORD_GOAL);
                        state_reg     <= DONE;
                    end else if (bus.sd_buff_wr && word_count_reg != WORD_MAX) begin
                        word_count_reg <= word_count_reg + 9'd1;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.sd_lba      = sd_lba_reg;
    assign bus.sd_rd       = sd_rd_reg;
    assign bus.owner       = owner_reg;
    assign bus.busy        = busy_reg;
    assign bus.aud_ack     = aud_ack_reg;
    assign bus.dat_ack     = dat_ack_reg;
    assign bus.aud_done    = aud_done_reg;
    assign bus.dat_done    = dat_done_reg;
    assign bus.short_err   = short_err_reg;
    assign bus.aud_buff_wr = strobe && !owner_reg;
    assign bus.dat_buff_wr = strobe && owner_reg;
endmodule
